// File: rtl/display_mode_pkg.sv
// Shared types and helpers for the display mode controller: layer-select
// encodings, the combined mode payload and the debounce state encoding.
package display_mode_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BG_CAMERA  = 2'd0,
    BG_CHANNEL = 2'd1,
    BG_THRESH  = 2'd2,
    BG_YMASK   = 2'd3
  } bg_mode_t;

  typedef enum logic [MODE_W-1:0] {
    TGT_NONE      = 2'd0,
    TGT_CROSSHAIR = 2'd1,
    TGT_SPRITE    = 2'd2,
    TGT_MARK      = 2'd3
  } target_mode_t;

  // bg occupies the upper two bits, matching the {bg, target} software word
  typedef struct packed {
    bg_mode_t     bg;
    target_mode_t target;
  } mode_sel_t;

  typedef enum logic [1:0] {
    DB_IDLE        = 2'd0,
    DB_ARM_PRESS   = 2'd1,
    DB_HELD        = 2'd2,
    DB_ARM_RELEASE = 2'd3
  } db_state_t;

  // Advance each selected field by one, wrapping 3 -> 0
  function automatic mode_sel_t step_modes(mode_sel_t cur, logic step_bg, logic step_tgt);
    mode_sel_t        nxt;
    logic [MODE_W-1:0] bg_raw;
    logic [MODE_W-1:0] tgt_raw;
    nxt     = cur;
    bg_raw  = cur.bg;
    tgt_raw = cur.target;
    if (step_bg) begin
      nxt.bg = bg_mode_t'(MODE_W'(bg_raw + MODE_W'(1)));
    end
    if (step_tgt) begin
      nxt.target = target_mode_t'(MODE_W'(tgt_raw + MODE_W'(1)));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw board button: two-flop synchroniser, debounce FSM producing a clean
// level, and a rising-edge detector on that level giving a one-cycle press.
module button_debouncer
  import display_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic press_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The sample that enters an ARM state is the first stable cycle, so the
  // counter stops one short of the full run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [1:0]       sync_q;
  logic             sync;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             clean_d_q;

  assign sync = sync_q[1];

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  // Debounce FSM: a level change needs DEBOUNCE_CYCLES consecutive agreeing samples
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      case (state_q)
        DB_IDLE: begin
          if (sync) begin
            state_q <= DB_ARM_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_ARM_PRESS: begin
          if (!sync) begin
            state_q <= DB_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_HELD;
            clean_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DB_HELD: begin
          if (!sync) begin
            state_q <= DB_ARM_RELEASE;
            cnt_q   <= '0;
          end
        end
        DB_ARM_RELEASE: begin
          if (sync) begin
            state_q <= DB_HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE;
            clean_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= DB_IDLE;
          cnt_q   <= '0;
          clean_q <= 1'b0;
        end
      endcase
    end
  end

  // Delayed clean level for edge detection
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clean_d_q <= 1'b0;
    end else begin
      clean_d_q <= clean_q;
    end
  end

  // High for exactly the first cycle of HELD
  assign press_c = clean_q & ~clean_d_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Layer-select controller for the pixel video mux. Button presses step shadow
// (pending) bg/target selects; the active selects load the shadow only on a
// new_frame_in pulse so a mode change never lands mid-frame.
// Optional feature macro: DISPLAY_MODE_SW_OVERRIDE_EN adds sw_override_in and
// sw_mode_in, letting software load the shadow directly.
module display_mode_ctrl
  import display_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [1:0]  RESET_BG        = 2'b00,
  parameter logic [1:0]  RESET_TARGET    = 2'b00
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       new_frame_in,
`ifdef DISPLAY_MODE_SW_OVERRIDE_EN
  input  logic       sw_override_in,
  input  logic [3:0] sw_mode_in,
`endif
  output logic [1:0] bg_out,
  output logic [1:0] target_out,
  output logic [1:0] pending_bg_out,
  output logic [1:0] pending_target_out,
  output logic       mode_changed_out
);

  localparam mode_sel_t RESET_SEL = mode_sel_t'({RESET_BG, RESET_TARGET});

  logic      bg_press_c;
  logic      tgt_press_c;
  mode_sel_t pending_q;
  mode_sel_t pending_nxt;
  mode_sel_t active_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_bg (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .btn_in (btn_bg_in),
    .press_c(bg_press_c)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_target (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .btn_in (btn_target_in),
    .press_c(tgt_press_c)
  );

  // Next shadow value; a commit in this cycle sees this value, not the old one
  always_comb begin
    pending_nxt = pending_q;
`ifdef DISPLAY_MODE_SW_OVERRIDE_EN
    if (sw_override_in) begin
      pending_nxt = mode_sel_t'(sw_mode_in);
    end else begin
      pending_nxt = step_modes(pending_q, bg_press_c, tgt_press_c);
    end
`else
    pending_nxt = step_modes(pending_q, bg_press_c, tgt_press_c);
`endif
  end

  // Shadow, active selects and the change strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q        <= RESET_SEL;
      active_q         <= RESET_SEL;
      mode_changed_out <= 1'b0;
    end else begin
      pending_q        <= pending_nxt;
      mode_changed_out <= 1'b0;
      if (new_frame_in) begin
        active_q         <= pending_nxt;
        mode_changed_out <= (pending_nxt != active_q);
      end
    end
  end

  assign bg_out             = active_q.bg;
  assign target_out         = active_q.target;
  assign pending_bg_out     = pending_q.bg;
  assign pending_target_out = pending_q.target;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl with DEBOUNCE_CYCLES=4: directed scenarios with
// literal expectations, then randomized buttons/frames/resets, all checked each
// cycle against a run-length behavioural model of the controller.
module tb_display_mode_ctrl;

  localparam int D = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       btn_bg_in = 1'b0;
  logic       btn_target_in = 1'b0;
  logic       new_frame_in = 1'b0;
  logic [1:0] bg_out;
  logic [1:0] target_out;
  logic [1:0] pending_bg_out;
  logic [1:0] pending_target_out;
  logic       mode_changed_out;

  int checks = 0;
  int errors = 0;

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RESET_BG       (2'b00),
    .RESET_TARGET   (2'b00)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .btn_bg_in         (btn_bg_in),
    .btn_target_in     (btn_target_in),
    .new_frame_in      (new_frame_in),
`ifdef DISPLAY_MODE_SW_OVERRIDE_EN
    .sw_override_in    (1'b0),
    .sw_mode_in        (4'd0),
`endif
    .bg_out            (bg_out),
    .target_out        (target_out),
    .pending_bg_out    (pending_bg_out),
    .pending_target_out(pending_target_out),
    .mode_changed_out  (mode_changed_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Behavioural model: index 0 = bg, 1 = target.
  // A button's debounced level flips after D consecutive synchronised samples
  // that disagree with it; a flip to 1 is a press visible for one cycle, and
  // the shadow counts it on the following edge.
  logic m_s1   [2] = '{1'b0, 1'b0};
  logic m_s2   [2] = '{1'b0, 1'b0};
  logic m_lvl  [2] = '{1'b0, 1'b0};
  logic m_press[2] = '{1'b0, 1'b0};
  int   m_run  [2] = '{0, 0};
  int   m_pend [2] = '{0, 0};
  int   m_act  [2] = '{0, 0};
  int   m_nxt  [2] = '{0, 0};
  logic m_raw  [2] = '{1'b0, 1'b0};
  logic m_chg = 1'b0;

  always @(posedge clk_in) begin
    m_raw[0] = btn_bg_in;
    m_raw[1] = btn_target_in;
    if (rst_in) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_press[b] = 1'b0;
        m_run[b] = 0; m_pend[b] = 0; m_act[b] = 0;
      end
      m_chg = 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) m_nxt[b] = (m_pend[b] + (m_press[b] ? 1 : 0)) % 4;
      m_chg = new_frame_in && ((m_nxt[0] != m_act[0]) || (m_nxt[1] != m_act[1]));
      for (int b = 0; b < 2; b++) begin
        if (new_frame_in) m_act[b] = m_nxt[b];
        m_pend[b]  = m_nxt[b];
        m_press[b] = 1'b0;
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b]   = m_s2[b];
            m_run[b]   = 0;
            m_press[b] = m_s2[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = m_raw[b];
      end
    end
  end

  // Cycle-by-cycle comparison against the model, shortly after each edge
  always @(posedge clk_in) begin
    #2;
    check("bg_out", int'(bg_out), m_act[0]);
    check("target_out", int'(target_out), m_act[1]);
    check("pending_bg_out", int'(pending_bg_out), m_pend[0]);
    check("pending_target_out", int'(pending_target_out), m_pend[1]);
    check("mode_changed_out", int'(mode_changed_out), int'(m_chg));
  end

  // One clean bg press: held long enough to register, then released long enough to settle
  task automatic press_bg();
    btn_bg_in = 1'b1;
    tick(7);
    btn_bg_in = 1'b0;
    tick(8);
  endtask

  initial begin
    // Reset held three cycles
    tick(3);
    check("rst_bg", int'(bg_out), 0);
    check("rst_target", int'(target_out), 0);
    check("rst_pend_bg", int'(pending_bg_out), 0);
    check("rst_pend_target", int'(pending_target_out), 0);
    check("rst_changed", int'(mode_changed_out), 0);
    rst_in = 1'b0;
    tick(2);

    // Bounce shorter than the debounce window: no press
    btn_bg_in = 1'b1;
    tick(3);
    btn_bg_in = 1'b0;
    tick(10);
    check("short_pend_bg", int'(pending_bg_out), 0);

    // Long hold: pulse after 2+D edges, shadow steps on the next edge
    btn_bg_in = 1'b1;
    tick(6);
    check("lat_pend_bg_before", int'(pending_bg_out), 0);
    tick(1);
    check("lat_pend_bg_after", int'(pending_bg_out), 1);
    check("lat_bg_out_held", int'(bg_out), 0);
    tick(3);
    btn_bg_in = 1'b0;
    tick(8);
    check("hold_pend_bg", int'(pending_bg_out), 1);
    check("hold_bg_out", int'(bg_out), 0);
    new_frame_in = 1'b1;
    tick(1);
    new_frame_in = 1'b0;
    check("commit_bg_out", int'(bg_out), 1);
    check("commit_changed", int'(mode_changed_out), 1);
    tick(1);
    check("commit_changed_clear", int'(mode_changed_out), 0);
    check("commit_bg_hold", int'(bg_out), 1);

    // Four presses wrap the shadow back to its committed value
    press_bg();
    check("wrap_1", int'(pending_bg_out), 2);
    press_bg();
    check("wrap_2", int'(pending_bg_out), 3);
    press_bg();
    check("wrap_3", int'(pending_bg_out), 0);
    press_bg();
    check("wrap_4", int'(pending_bg_out), 1);
    new_frame_in = 1'b1;
    tick(1);
    new_frame_in = 1'b0;
    check("wrap_bg_out", int'(bg_out), 1);
    check("wrap_changed", int'(mode_changed_out), 0);

    // Target press pulse in the same cycle as new_frame_in
    btn_target_in = 1'b1;
    tick(6);
    new_frame_in = 1'b1;
    tick(1);
    new_frame_in = 1'b0;
    check("coinc_target_out", int'(target_out), 1);
    check("coinc_changed", int'(mode_changed_out), 1);
    btn_target_in = 1'b0;
    tick(8);

    // Reset during ARM_PRESS with the button still held
    btn_target_in = 1'b1;
    tick(5);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    check("rstmid_pend_target", int'(pending_target_out), 0);
    tick(5);
    check("rstmid_before", int'(pending_target_out), 0);
    tick(1);
    check("rstmid_still0", int'(pending_target_out), 0);
    tick(1);
    check("rstmid_press", int'(pending_target_out), 1);
    tick(10);
    check("rstmid_once", int'(pending_target_out), 1);
    btn_target_in = 1'b0;
    tick(8);

    // Randomized buttons, frames and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) btn_bg_in = ~btn_bg_in;
      if ($urandom_range(0, 3) == 0) btn_target_in = ~btn_target_in;
      new_frame_in = ($urandom_range(0, 5) == 0);
      rst_in       = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst_in = 1'b0;
    new_frame_in = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
